// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Two-entry pipeline stage (main + skid) with valid/ready handshakes, a global
// stall, a priority flush, and a saturating counter of entries lost to flush.
//
// The stage is a small FSM (EMPTY / ONE / FULL). Every output is a register:
// in_ready, out_valid and occupancy are updated together with the state, so
// in_ready never has a combinational path from any input. out_data is the
// main payload register itself.
//
// Ports
//   CLK        in   1       clock, rising edge
//   RST        in   1       synchronous active-high reset, overrides everything
//   in_valid   in   1       upstream offers in_data
//   in_ready   out  1       stage can accept (registered, 0 only when FULL)
//   in_data    in   WIDTH   upstream payload
//   out_valid  out  1       out_data holds a valid entry
//   out_ready  in   1       downstream consumes this cycle
//   out_data   out  WIDTH   oldest entry (main payload register)
//   stall      in   1       freeze all state
//   flush      in   1       discard all entries (wins over stall/handshakes)
//   occupancy  out  2       number of valid entries, 0..2
//   drop_cnt   out  CNT_W   saturating count of entries discarded by flush
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int WIDTH          = 32,
  parameter bit CLEAR_ON_FLUSH = 1'b1,
  parameter int CNT_W          = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             stall,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stateT;

  // Two extra bits so that adding an occupancy of up to 2 can never wrap
  // before the saturation compare, even for CNT_W = 1.
  localparam int SUM_W = CNT_W + 2;
  localparam logic [SUM_W-1:0] DROP_MAX = SUM_W'({CNT_W{1'b1}});

  stateT            stateReg;
  logic [WIDTH-1:0] mainReg;
  logic [WIDTH-1:0] skidReg;
  logic             outValidReg;
  logic             inReadyReg;
  logic [1:0]       occReg;
  logic [CNT_W-1:0] dropReg;

  logic             accept;
  logic             consume;
  logic [SUM_W-1:0] dropSum;
  logic [CNT_W-1:0] dropNext;

  // Handshakes only count when the stage is neither frozen nor being flushed.
  assign accept  = in_valid  & inReadyReg  & ~stall & ~flush;
  assign consume = out_ready & outValidReg & ~stall & ~flush;

  // Flush discards exactly the entries currently held.
  assign dropSum  = SUM_W'(dropReg) + SUM_W'(occReg);
  assign dropNext = (dropSum > DROP_MAX) ? {CNT_W{1'b1}} : dropSum[CNT_W-1:0];

  always_ff @(posedge CLK) begin
    if (RST) begin
      stateReg    <= EMPTY;
      mainReg     <= '0;
      skidReg     <= '0;
      outValidReg <= 1'b0;
      inReadyReg  <= 1'b1;
      occReg      <= 2'd0;
      dropReg     <= '0;
    end else if (flush) begin
      // Same-cycle in_data is dropped; stall is irrelevant here.
      stateReg    <= EMPTY;
      outValidReg <= 1'b0;
      inReadyReg  <= 1'b1;
      occReg      <= 2'd0;
      dropReg     <= dropNext;
      if (CLEAR_ON_FLUSH) begin
        mainReg <= '0;
        skidReg <= '0;
      end
    end else if (!stall) begin
      case (stateReg)
        EMPTY: begin
          if (accept) begin
            mainReg     <= in_data;
            stateReg    <= ONE;
            outValidReg <= 1'b1;
            occReg      <= 2'd1;
          end
        end

        ONE: begin
          if (accept && consume) begin
            // Pass-through at full rate: the new word replaces the consumed one.
            mainReg <= in_data;
          end else if (accept) begin
            // Downstream is blocked; park the new word behind main.
            skidReg    <= in_data;
            stateReg   <= FULL;
            inReadyReg <= 1'b0;
            occReg     <= 2'd2;
          end else if (consume) begin
            // Payload is left as-is; only the valid flag drops.
            stateReg    <= EMPTY;
            outValidReg <= 1'b0;
            occReg      <= 2'd0;
          end
        end

        FULL: begin
          // in_ready is low, so no accept can coincide with this move.
          if (consume) begin
            mainReg    <= skidReg;
            stateReg   <= ONE;
            inReadyReg <= 1'b1;
            occReg     <= 2'd1;
          end
        end

        default: begin
          // Unreachable encoding: fall back to a consistent empty stage.
          stateReg    <= EMPTY;
          outValidReg <= 1'b0;
          inReadyReg  <= 1'b1;
          occReg      <= 2'd0;
        end
      endcase
    end
  end

  assign in_ready  = inReadyReg;
  assign out_valid = outValidReg;
  assign out_data  = mainReg;
  assign occupancy = occReg;
  assign drop_cnt  = dropReg;

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter WIDTH, default 32, payload width in bits (WIDTH >= 1).
REQ-002 Parameter CLEAR_ON_FLUSH, default 1: 1 zeroes payload storage on flush; 0 leaves payload storage unchanged.
REQ-003 Parameter CNT_W, default 8, width of the drop counter.
REQ-004 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-005 RST  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  upstream offers in_data this cycle.
REQ-007 in_ready  output  1  stage can accept this cycle; a registered signal with no combinational path from any input.
REQ-008 in_data  input  WIDTH  upstream payload.
REQ-009 out_valid  output  1  out_data holds a valid entry.
REQ-010 out_ready  input  1  downstream consumes this cycle.
REQ-011 out_data  output  WIDTH  payload of the oldest entry; driven directly from a register.
REQ-012 stall  input  1  global freeze, such as a cache miss.
REQ-013 flush  input  1  discard all contents, such as a mispredict.
REQ-014 occupancy  output  2  number of valid entries, 0 to 2.
REQ-015 drop_cnt  output  CNT_W  saturating count of valid entries discarded by flush.

Function
REQ-016 Storage is two entries: main, which drives the outputs, and skid; skid is never valid while main is empty.
REQ-017 States: EMPTY (occupancy 0), ONE (main valid), FULL (main and skid valid); occupancy, out_valid and in_ready SHALL be consistent with the state at all times.
REQ-018 in_ready SHALL be 1 in EMPTY and ONE and 0 in FULL.
REQ-019 An accept is in_valid & in_ready & !stall & !flush; a consume is out_valid & out_ready & !stall & !flush.
REQ-020 EMPTY: on accept, load main and go to ONE; out_valid rises one cycle after the accept, giving 1-cycle latency.
REQ-021 ONE: on accept only, load skid and go to FULL; on consume only, go to EMPTY; on accept and consume together, load main with in_data and stay in ONE, giving full throughput.
REQ-022 FULL: on consume, move skid to main and go to ONE; no accept is possible in FULL.
REQ-023 stall=1 with flush=0 SHALL hold all state, outputs and drop_cnt unchanged, regardless of in_valid and out_ready.
REQ-024 flush=1 SHALL have priority over stall, accept and consume.
REQ-025 On flush, next state is EMPTY, same-cycle in_data is discarded, and, if CLEAR_ON_FLUSH=1, main and skid payloads become 0.
REQ-026 On flush, drop_cnt increases by the current occupancy (0, 1 or 2) and saturates at 2^CNT_W-1 without wrapping.
REQ-027 Data order SHALL be strictly FIFO, with no loss or duplication except through flush.
REQ-028 out_data SHALL remain stable while out_valid=1 and no consume occurs.
REQ-029 Payload registers are written only on load, move or flush-clear.

Reset
REQ-030 While RST=1 at a rising edge: state EMPTY, out_valid=0, in_ready=1 on the following cycle, occupancy=0, out_data=0, skid payload=0, drop_cnt=0.
REQ-031 RST SHALL override flush, stall and all handshakes.
REQ-032 Reset asserted mid-transfer SHALL discard all entries without incrementing drop_cnt.
REQ-033 The first accept is possible in the first cycle after RST deasserts.

Verification
REQ-034 Bench streams 0x11, 0x22, 0x33 with in_valid=1 and out_ready=1 constant -> out_data shows 0x11, 0x22, 0x33 on consecutive cycles starting one cycle after the first accept; occupancy stays 1.
REQ-035 Bench accepts 0xA then 0xB with out_ready=0 -> occupancy=2, in_ready=0, out_data=0xA held; bench then raises out_ready -> bench sees 0xA then 0xB, in_ready=1 after the first consume.
REQ-036 Bench asserts stall=1 for 3 cycles in FULL with out_ready=1 and in_valid=1 -> state, out_data and occupancy are unchanged; after release, output order is unchanged.
REQ-037 Bench asserts flush and stall together in FULL with in_valid=1 -> next cycle occupancy=0, out_valid=0, out_data=0 (CLEAR_ON_FLUSH=1), drop_cnt increments by 2.
REQ-038 With CNT_W=2, bench applies three flushes in FULL -> drop_cnt goes 2, then 3, then stays at 3.
REQ-039 Bench asserts RST while FULL and drop_cnt=1 -> next cycle occupancy=0, in_ready=1, out_data=0, drop_cnt=0.
